add_seq_nbits: RTL



---
 rtl/add_seq_pkg.sv | 24 ++
 rtl/add_seg.sv | 38 +++
 rtl/add_seq_nbits.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types and constants for the segmented sequential adder
//
// Purpose : FSM state encoding, default operand/segment widths and the
//           segment-counter width helper used by add_seq_nbits and add_seg.
// Ports   : none (package).
// Options : ADD_SEQ_SUB_EN (used by add_seq_nbits) adds a subtract mode.

package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADD_SEQ_WIDTH = 24;
  localparam int ADD_SEQ_SEG_W = 6;

  // Counter must index 0..num_seg-1; a single-segment build still needs one bit.
  function automatic int cnt_width(input int num_seg);
    return (num_seg <= 1) ? 1 : $clog2(num_seg);
  endfunction

endpackage

// File: rtl/add_seg.sv
// rtl/add_seg.sv - SEG_W-bit combinational ripple-carry adder slice
//
// Purpose : one segment of the sequential adder; the top time-multiplexes
//           this single instance across all segments of the operands.
// Ports   : i_data_one [SEG_W] - segment of operand A
//           i_data_two [SEG_W] - segment of operand B
//           i_carry            - carry into the segment
//           o_data     [SEG_W] - segment sum
//           o_carry            - carry out of the segment MSB

module add_seg
  import add_seq_pkg::*;
#(
  parameter int SEG_W = ADD_SEQ_SEG_W
) (
  input  logic [SEG_W-1:0] i_data_one,
  input  logic [SEG_W-1:0] i_data_two,
  input  logic             i_carry,
  output logic [SEG_W-1:0] o_data,
  output logic             o_carry
);

  logic [SEG_W:0] w_c;

  always_comb begin
    w_c    = '0;
    o_data = '0;
    w_c[0] = i_carry;
    for (int i = 0; i < SEG_W; i++) begin
      o_data[i]  = i_data_one[i] ^ i_data_two[i] ^ w_c[i];
      w_c[i + 1] = (i_data_one[i] & i_data_two[i]) |
                   (w_c[i] & (i_data_one[i] ^ i_data_two[i]));
    end
  end

  assign o_carry = w_c[SEG_W];

endmodule

// File: rtl/add_seq_nbits.sv
// rtl/add_seq_nbits.sv - multi-cycle segmented adder, SEG_W bits per clock
//
// Purpose : adds two WIDTH-bit operands plus carry-in over NUM_SEG cycles,
//           carrying between segments through a register. Valid/ready
//           handshake on input and output; one operation in flight.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_valid / o_ready        - operand handshake
//           i_data_one, i_data_two   - operands A, B [WIDTH]
//           i_carry                  - carry-in
//           i_sub                    - subtract select (ADD_SEQ_SUB_EN only)
//           o_valid / i_ready        - result handshake
//           o_data [WIDTH], o_carry  - sum and carry-out of the MSB segment
// Options : ADD_SEQ_SUB_EN - when defined, adds i_sub; i_sub=1 computes
//           A + ~B + 1 and o_carry=1 means no borrow.

module add_seq_nbits
  import add_seq_pkg::*;
#(
  parameter int WIDTH = ADD_SEQ_WIDTH,
  parameter int SEG_W = ADD_SEQ_SEG_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_one,
  input  logic [WIDTH-1:0] i_data_two,
  input  logic             i_carry,
`ifdef ADD_SEQ_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);

  localparam int NUM_SEG = WIDTH / SEG_W;
  localparam int CNT_W   = cnt_width(NUM_SEG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SEG - 1);

  generate
    if ((WIDTH % SEG_W) != 0) begin : g_width_check
      $error("add_seq_nbits: WIDTH must be a multiple of SEG_W");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic             r_ocarry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [31:0]      w_shamt;
  logic [SEG_W-1:0] w_seg_a;
  logic [SEG_W-1:0] w_seg_b;
  logic [SEG_W-1:0] w_seg_sum;
  logic             w_seg_cout;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_ins;
  logic [WIDTH-1:0] w_data_next;

  // Subtraction is folded into the operand capture so the datapath only
  // ever adds: A - B == A + ~B + 1.
`ifdef ADD_SEQ_SUB_EN
  assign w_b_in   = i_sub ? ~i_data_two : i_data_two;
  assign w_cin_in = i_sub ? 1'b1 : i_carry;
`else
  assign w_b_in   = i_data_two;
  assign w_cin_in = i_carry;
`endif

  assign w_accept = i_valid && o_ready;
  assign w_last   = (r_cnt == LAST_CNT);

  // Segment selection by shifting keeps the index arithmetic out of
  // part-select bounds, which also keeps NUM_SEG=1 legal.
  assign w_shamt = 32'(r_cnt) * 32'(SEG_W);
  assign w_seg_a = SEG_W'(r_a >> w_shamt);
  assign w_seg_b = SEG_W'(r_b >> w_shamt);

  add_seg #(
    .SEG_W(SEG_W)
  ) u_add_seg (
    .i_data_one(w_seg_a),
    .i_data_two(w_seg_b),
    .i_carry   (r_carry),
    .o_data    (w_seg_sum),
    .o_carry   (w_seg_cout)
  );

  // Only the active slice of the result register is rewritten each cycle.
  assign w_mask      = WIDTH'({SEG_W{1'b1}}) << w_shamt;
  assign w_ins       = WIDTH'(w_seg_sum) << w_shamt;
  assign w_data_next = (r_data & ~w_mask) | w_ins;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = BUSY;
      BUSY:    if (w_last)   w_next_state = DONE;
      DONE:    if (i_ready)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      IDLE:    o_ready = 1'b1;
      DONE:    o_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_data   <= '0;
      r_carry  <= 1'b0;
      r_ocarry <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a     <= i_data_one;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_cnt   <= '0;
    end else if (r_state == BUSY) begin
      r_data  <= w_data_next;
      r_carry <= w_seg_cout;
      if (w_last) begin
        r_ocarry <= w_seg_cout;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_data  = r_data;
  assign o_carry = r_ocarry;

endmodule
